// File: rtl/uart2wb_pkg.sv
// Shared types and constants for the UART-to-Wishbone bridge.
package uart2wb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StBus,
    StRdata,
    StStatus,
    StDrain
  } state_e;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BUSERR  = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;

  localparam int unsigned CMD_WR_BIT = 7;

endpackage

// File: rtl/uart2wb_if.sv
// Wishbone classic bus bundle between the bridge (master) and the interconnect (slave).
interface uart2wb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [ADDR_W-1:0]     wb_adr;
  logic [DATA_W-1:0]     wb_dat_o;
  logic [DATA_W/8-1:0]   wb_sel;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_ack;
  logic                  wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
    input  wb_dat_i, wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
    output wb_dat_i, wb_ack, wb_err
  );

endinterface

// File: rtl/uart2wb_shift.sv
// Byte<->word shift register: shifts bytes in at the LSB end (MSB-first stream) or
// loads a whole word; last_o flags the final byte position of the current word.
module uart2wb_shift
  import uart2wb_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] word_i,
  input  logic         shift_i,
  input  logic [7:0]   byte_i,
  output logic [W-1:0] word_o,
  output logic         last_o
);

  localparam int unsigned NB   = W / 8;
  localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;

  logic [W-1:0]    word_q, word_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CntW'(NB - 1));
  assign word_o = word_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      word_d = (word_q << 8) | W'(byte_i);
      cnt_d  = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart2wb_bridge.sv
// UART byte-stream command decoder driving Wishbone classic single cycles with bursts.
// Optional ack timeout is compiled in with UART2WB_TIMEOUT_EN.
module uart2wb_bridge
  import uart2wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  uart2wb_if.master  wb
);

  localparam int unsigned NB = DATA_W / 8;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [7:0]        status_q, status_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              a_shift, a_load, a_last;
  logic [ADDR_W-1:0] adr;
  logic              d_shift, d_load, d_last;
  logic [DATA_W-1:0] d_word, d_load_val, d_word_shl;
  logic [7:0]        d_byte_in, err_code;
  logic              rx_fire, tx_fire, term_ok, term_err, tmo_hit;

  assign rx_fire  = rx_valid & rx_ready_q;
  assign tx_fire  = tx_valid_q & tx_ready;
  // ack+err together counts as err; a coincident ack beats the timeout
  assign term_err = cyc_q & (wb.wb_err | (tmo_hit & ~wb.wb_ack));
  assign term_ok  = cyc_q & wb.wb_ack & ~wb.wb_err;
  assign err_code = wb.wb_err ? STATUS_BUSERR : STATUS_TIMEOUT;
  assign d_word_shl = d_word << 8;

`ifdef UART2WB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  assign tmo_hit = cyc_q && (tmo_q == TmoW'(TIMEOUT - 1));
  assign tmo_d   = (cyc_q && !wb.wb_ack && !wb.wb_err && !tmo_hit) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  uart2wb_shift #(.W(ADDR_W)) u_adr_shift (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (a_load),
    .word_i  (adr + ADDR_W'(NB)),
    .shift_i (a_shift),
    .byte_i  (rx_data),
    .word_o  (adr),
    .last_o  (a_last)
  );

  uart2wb_shift #(.W(DATA_W)) u_dat_shift (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (d_load),
    .word_i  (d_load_val),
    .shift_i (d_shift),
    .byte_i  (d_byte_in),
    .word_o  (d_word),
    .last_o  (d_last)
  );

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    left_d     = left_q;
    status_d   = status_q;
    cyc_d      = cyc_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    a_shift    = 1'b0;
    a_load     = 1'b0;
    d_shift    = 1'b0;
    d_load     = 1'b0;
    d_load_val = '0;
    d_byte_in  = rx_data;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          is_wr_d  = rx_data[CMD_WR_BIT];
          left_d   = rx_data[LEN_W-1:0];
          status_d = STATUS_OK;
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (rx_fire) begin
          a_shift = 1'b1;
          if (a_last) begin
            if (is_wr_q) begin
              state_d = StWdata;
            end else begin
              state_d = StBus;
              cyc_d   = 1'b1;
            end
          end
        end
      end
      StWdata: begin
        if (rx_fire) begin
          d_shift = 1'b1;
          if (d_last) begin
            state_d = StBus;
            cyc_d   = 1'b1;
          end
        end
      end
      StBus: begin
        if (term_ok || term_err) begin
          cyc_d  = 1'b0;
          a_load = 1'b1;
          if (term_err) status_d = err_code;
          if (is_wr_q) begin
            if (left_q == '0) begin
              state_d    = StStatus;
              tx_valid_d = 1'b1;
              tx_data_d  = status_d;
            end else begin
              left_d  = left_q - 1'b1;
              state_d = term_err ? StDrain : StWdata;
            end
          end else begin
            // a failed read word is replaced by zeros so the host byte count is fixed
            d_load     = 1'b1;
            d_load_val = term_err ? '0 : wb.wb_dat_i;
            state_d    = StRdata;
            tx_valid_d = 1'b1;
            tx_data_d  = term_err ? 8'h00 : wb.wb_dat_i[DATA_W-1 -: 8];
          end
        end
      end
      StRdata: begin
        if (tx_fire) begin
          d_shift   = 1'b1;
          d_byte_in = 8'h00;
          tx_data_d = d_word_shl[DATA_W-1 -: 8];
          if (d_last) begin
            if (left_q == '0) begin
              state_d   = StStatus;
              tx_data_d = status_q;
            end else begin
              left_d = left_q - 1'b1;
              if (status_q != STATUS_OK) begin
                d_load    = 1'b1;
                tx_data_d = 8'h00;
              end else begin
                state_d    = StBus;
                cyc_d      = 1'b1;
                tx_valid_d = 1'b0;
              end
            end
          end
        end
      end
      StDrain: begin
        if (rx_fire) begin
          d_shift = 1'b1;
          if (d_last) begin
            if (left_q == '0) begin
              state_d    = StStatus;
              tx_valid_d = 1'b1;
              tx_data_d  = status_q;
            end else begin
              left_d = left_q - 1'b1;
            end
          end
        end
      end
      StStatus: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    we_d       = cyc_d & is_wr_q;
    rx_ready_d = (state_d == StIdle) || (state_d == StAddr) ||
                 (state_d == StWdata) || (state_d == StDrain);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_wr_q    <= 1'b0;
      left_q     <= '0;
      status_q   <= STATUS_OK;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      left_q     <= left_d;
      status_q   <= status_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign wb.wb_cyc   = cyc_q;
  assign wb.wb_stb   = cyc_q;
  assign wb.wb_we    = we_q;
  assign wb.wb_adr   = adr;
  assign wb.wb_dat_o = d_word;
  assign wb.wb_sel   = {NB{cyc_q}};

endmodule

// File: tb/tb_uart2wb_bridge.sv
// Directed bench for uart2wb_bridge: UART frame driver, TX collector and a Wishbone slave model.
module tb_uart2wb_bridge;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  int n_total = 0;
  int n_bad   = 0;

  // slave model controls and log
  int          err_at      = -1;
  bit          no_ack      = 1'b0;
  int          resp_delay  = 0;
  int          cyc_hi      = 0;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];
  logic [31:0] mem [logic [31:0]];

  uart2wb_if #(.ADDR_W(32), .DATA_W(32)) wbi ();

  uart2wb_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .LEN_W   (6),
    .TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .wb       (wbi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wishbone slave: responds after resp_delay cyc-high cycles, logs each terminated cycle
  initial begin
    int wait_n;
    wait_n        = 0;
    wbi.wb_ack    = 1'b0;
    wbi.wb_err    = 1'b0;
    wbi.wb_dat_i  = '0;
    forever begin
      @(negedge clk);
      wbi.wb_ack = 1'b0;
      wbi.wb_err = 1'b0;
      if (wbi.wb_cyc && rst_n) begin
        cyc_hi++;
        if (!no_ack) begin
          if (wait_n < resp_delay) begin
            wait_n++;
          end else begin
            wait_n = 0;
            log_adr.push_back(wbi.wb_adr);
            log_dat.push_back(wbi.wb_dat_o);
            log_we.push_back(wbi.wb_we);
            log_sel.push_back(wbi.wb_sel);
            if (log_adr.size() - 1 == err_at) begin
              wbi.wb_err = 1'b1;
            end else begin
              wbi.wb_ack   = 1'b1;
              wbi.wb_dat_i = mem.exists(wbi.wb_adr) ? mem[wbi.wb_adr] : 32'h0;
            end
          end
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
    log_we.delete();
    log_sel.delete();
    cyc_hi = 0;
  endtask

  // called and returns at a negedge; back-to-back calls give one byte per cycle
  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check_eq("rx_ready_wait", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n;
    n        = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) check_eq("tx_valid_wait", 64'(tx_valid), 64'd1);
    b = tx_data;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp[$]);
    logic [7:0] b;
    foreach (exp[i]) begin
      recv_byte(b);
      check_eq($sformatf("%s_tx%0d", tag, i), 64'(b), 64'(exp[i]));
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_txidle"}, 64'(tx_valid), 64'd0);
  endtask

  // hold tx_ready low for 20 cycles per byte and require a stable presentation
  task automatic expect_tx_stalled(input string tag, input logic [7:0] exp[$]);
    logic [7:0] b;
    bit stable;
    int n;
    foreach (exp[i]) begin
      n        = 0;
      tx_ready = 1'b0;
      while (!tx_valid && n < 2000) begin
        @(negedge clk);
        n++;
      end
      b      = tx_data;
      stable = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (!tx_valid || tx_data !== b) stable = 1'b0;
      end
      check_eq($sformatf("%s_stable%0d", tag, i), 64'(stable), 64'd1);
      check_eq($sformatf("%s_tx%0d", tag, i), 64'(b), 64'(exp[i]));
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] ex[$];
    bit quiet;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    mem[32'h10] = 32'h11111111;
    mem[32'h14] = 32'h22222222;
    mem[32'h18] = 32'h33333333;
    mem[32'h1C] = 32'h44444444;
    mem[32'h20] = 32'hCAFEF00D;
    mem[32'h24] = 32'h01234567;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_rx_ready", 64'(rx_ready), 64'd0);
    check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("rst_tx_data", 64'(tx_data), 64'd0);
    check_eq("rst_cyc", 64'(wbi.wb_cyc), 64'd0);
    check_eq("rst_we", 64'(wbi.wb_we), 64'd0);
    check_eq("rst_adr", 64'(wbi.wb_adr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_rx_ready", 64'(rx_ready), 64'd1);

    // single-word write
    clear_log();
    fr = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(fr);
    check_eq("w1_cyc_start", 64'(wbi.wb_cyc), 64'd1);
    ex = '{8'h00};
    expect_tx("w1", ex);
    check_eq("w1_ncyc", 64'(log_adr.size()), 64'd1);
    check_eq("w1_adr", 64'(log_adr[0]), 64'h10);
    check_eq("w1_dat", 64'(log_dat[0]), 64'hDEADBEEF);
    check_eq("w1_we", 64'(log_we[0]), 64'd1);
    check_eq("w1_sel", 64'(log_sel[0]), 64'hF);

    // 4-word read burst
    clear_log();
    fr = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h10};
    send_frame(fr);
    ex = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
           8'h33, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h44, 8'h00};
    expect_tx("r4", ex);
    check_eq("r4_ncyc", 64'(log_adr.size()), 64'd4);
    check_eq("r4_adr0", 64'(log_adr[0]), 64'h10);
    check_eq("r4_adr1", 64'(log_adr[1]), 64'h14);
    check_eq("r4_adr2", 64'(log_adr[2]), 64'h18);
    check_eq("r4_adr3", 64'(log_adr[3]), 64'h1C);
    check_eq("r4_we", 64'(log_we[3]), 64'd0);

    // 3-word write, error on the second word: remaining bytes drained
    clear_log();
    err_at = 1;
    fr = '{8'h82, 8'h00, 8'h00, 8'h01, 8'h00,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
           8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_frame(fr);
    ex = '{8'h01};
    expect_tx("werr", ex);
    err_at = -1;
    check_eq("werr_ncyc", 64'(log_adr.size()), 64'd2);
    check_eq("werr_adr1", 64'(log_adr[1]), 64'h104);
    check_eq("werr_dat1", 64'(log_dat[1]), 64'h05060708);

    // 3-word read, error on the second word: zeros stand in for the lost words
    clear_log();
    err_at = 1;
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h10};
    send_frame(fr);
    ex = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    expect_tx("rerr", ex);
    err_at = -1;
    check_eq("rerr_ncyc", 64'(log_adr.size()), 64'd2);

    // 2-word read with TX stalls and a slow slave
    clear_log();
    resp_delay = 3;
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
    send_frame(fr);
    ex = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
    expect_tx_stalled("rstall", ex);
    repeat (5) @(negedge clk);
    resp_delay = 0;
    check_eq("rstall_ncyc", 64'(log_adr.size()), 64'd2);
    check_eq("rstall_adr1", 64'(log_adr[1]), 64'h24);

    // 2-word write across the top of the address space
    clear_log();
    fr = '{8'h81, 8'hFF, 8'hFF, 8'hFF, 8'hFC,
           8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(fr);
    ex = '{8'h00};
    expect_tx("wrap", ex);
    check_eq("wrap_adr0", 64'(log_adr[0]), 64'hFFFFFFFC);
    check_eq("wrap_adr1", 64'(log_adr[1]), 64'h0);
    check_eq("wrap_dat1", 64'(log_dat[1]), 64'h11223344);

`ifdef UART2WB_TIMEOUT_EN
    // no ack: the cycle is abandoned after TIMEOUT cycles
    clear_log();
    no_ack = 1'b1;
    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
    send_frame(fr);
    ex = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    expect_tx("tmo", ex);
    no_ack = 1'b0;
    check_eq("tmo_cyc_len", 64'(cyc_hi), 64'd15);
`endif

    // reset in the middle of the address: frame dropped silently
    clear_log();
    fr = '{8'h80, 8'h00, 8'h00};
    send_frame(fr);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_rx_ready", 64'(rx_ready), 64'd0);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid || wbi.wb_cyc) quiet = 1'b0;
    end
    check_eq("mrst_quiet", 64'(quiet), 64'd1);
    fr = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h30, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(fr);
    ex = '{8'h00};
    expect_tx("mrst", ex);
    check_eq("mrst_ncyc", 64'(log_adr.size()), 64'd1);
    check_eq("mrst_adr", 64'(log_adr[0]), 64'h30);
    check_eq("mrst_dat", 64'(log_dat[0]), 64'h12345678);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart2wb_bridge.md
# uart2wb_bridge

Parametrised UART-byte-stream to Wishbone master bridge for host access to on-chip memory and registers. It accepts framed read/write commands from a UART RX byte stream and performs Wishbone classic single cycles. Commands may be bursts with address auto-increment, and bus errors are reported back to the host. It sits between the UART RX/TX byte interfaces and the Wishbone interconnect in FPGA top-level designs.

## Interface
- ADDR_W, 32, Wishbone byte-address width; multiple of 8 (8..32).
- DATA_W, 32, Wishbone data width; one of 8, 16, 32, 64.
- LEN_W, 6, burst length field width; max burst 2^LEN_W words.
- TIMEOUT, 1023, ack wait limit in cycles (used only with timeout compiled in).
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_valid  in  1  RX byte valid.
- rx_data  in  8  RX byte.
- rx_ready  out  1  bridge accepts RX byte.
- tx_valid  out  1  TX byte valid.
- tx_data  out  8  TX byte.
- tx_ready  in  1  TX sink accepts byte.
- wb_cyc / wb_stb  out  1  cycle/strobe (always equal).
- wb_we  out  1  write enable.
- wb_adr  out  ADDR_W  byte address.
- wb_dat_o  out  DATA_W  write data.
- wb_sel  out  DATA_W/8  byte select (all ones).
- wb_dat_i  in  DATA_W  read data.
- wb_ack / wb_err  in  1  termination.

## Operation
- Frame: CMD byte, then ADDR_W/8 address bytes (MSB first), then for writes N×DATA_W/8 data bytes (MSB first per word).
- CMD[7] = 1 write / 0 read; CMD[6] reserved (ignored); CMD[LEN_W-1:0] = N-1.
- Address increments by DATA_W/8 after each word. It wraps modulo 2^ADDR_W.
- Response for a write: one STATUS byte after the last word. Response for a read: N×DATA_W/8 data bytes (MSB first), then STATUS.
- STATUS: 0x00 OK, 0x01 wb_err, 0x02 timeout.
- FSM states: IDLE → ADDR → (write: WDATA ⇄ BUS) / (read: BUS ⇄ RDATA) → STATUS → IDLE. DRAIN is entered on a write error.
- rx_ready = 1 only in IDLE, ADDR, WDATA and DRAIN.
- Write error: the bridge aborts all remaining bus cycles. It consumes the remaining write data bytes in DRAIN and discards them, then sends STATUS.
- Read error: the bridge aborts all remaining bus cycles. The failing word and all remaining words are sent as 0x00 bytes, so the host byte count is fixed; then STATUS.
- Once an error is recorded, STATUS always reports the first error.
- wb_ack and wb_err asserted together: treated as err.

## Timing
- Reset values: all outputs 0, FSM = IDLE, and status is cleared. rx_ready = 0 while rst_n is low and 1 from the first cycle after release.
- Reset mid-frame: the frame is dropped and no response is sent. An in-flight Wishbone cycle drops wb_cyc/wb_stb on the next edge.
- RX byte transfer: accepted on rx_valid & rx_ready at a rising edge. Throughput is one byte per cycle.
- Bus cycle start: wb_cyc/wb_stb rise on the cycle after the word's last byte (for writes) or after the last address byte or previous word send (for reads).
- Bus cycle hold: wb_cyc/wb_stb stay high with stable wb_adr/wb_we/wb_dat_o until ack/err is sampled. They are deasserted on the following cycle.
- Read data: captured on the edge where ack is sampled. The first tx_valid appears 1 cycle later.
- TX byte transfer: tx_valid/tx_data are registered and held stable until tx_ready. The next byte is presented on the cycle after acceptance.
- Backpressure: no RX bytes are accepted while a response is pending.

## Configuration
- UART2WB_TIMEOUT_EN defined: a counter runs while wb_cyc is high. When it reaches TIMEOUT cycles without ack/err, the bridge aborts the cycle (wb_cyc low next edge) and records status 0x02; error handling is as for wb_err.
- UART2WB_TIMEOUT_EN undefined: no counter and no 0x02 status; the bridge waits indefinitely for ack/err.

## Structure
- Package uart2wb_pkg holds:
  - FSM state enum;
  - STATUS_OK/STATUS_BUSERR/STATUS_TIMEOUT constants;
  - CMD_WR_BIT position.
- Sub-module uart2wb_shift: a parametrised byte↔word shift register. It loads or shifts by one byte and flags last byte; it is instantiated once for address and once for data.

## Test plan
- Write 1 word (DATA_W=32, ADDR_W=32): bytes 80 00 00 00 10 DE AD BE EF → one cycle at adr 0x10 with dat 0xDEADBEEF; TX 0x00.
- Read burst: bytes 03 00 00 00 10 (4 words), slave returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 at adr 0x10/14/18/1C → TX those 16 bytes MSB first, then 0x00.
- Write burst of 3 with wb_err on the 2nd word → exactly 2 bus cycles, 3rd word's bytes drained, TX 0x01.
- Read burst of 2 with tx_ready low for 20 cycles on each byte → tx_data stable while stalled, no extra bus cycle, correct byte order.
- With UART2WB_TIMEOUT_EN and TIMEOUT=15, read with no ack → wb_cyc low after 15 cycles, TX 00 00 00 00 02.
- rst_n low for 1 cycle mid-address → no TX; next full write frame completes normally with TX 0x00.
